// File: rtl/pc_sequencer.sv
// pc_sequencer: program counter with branch/jump/call/return selection and circular return-address stack
module pc_sequencer #(
  parameter int PC_W      = 12,
  parameter int OFF_W     = 17,
  parameter int RAS_DEPTH = 4
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             stall_i,
  input  logic             branch_taken_i,
  input  logic [OFF_W-1:0] branch_offset_i,
  input  logic             jump_i,
  input  logic             call_i,
  input  logic             ret_i,
  input  logic [PC_W-1:0]  jump_target_i,
  output logic [PC_W-1:0]  pc_o,
  output logic [PC_W-1:0]  pc_plus1_o,
  output logic             ras_empty_o,
  output logic             ras_full_o,
  output logic             ras_overflow_o,
  output logic             ras_underflow_o
);
  localparam int PW = $clog2(RAS_DEPTH);
  localparam int CW = PW + 1;
  localparam int SW = (OFF_W > PC_W) ? OFF_W : PC_W;
  logic [PC_W-1:0] pc_q, pc_d, br_tgt;
  logic [PC_W-1:0] ras_q [RAS_DEPTH];
  logic [PW-1:0]   top_q, top_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            ovf_q, ovf_d, unf_q, unf_d;
  logic            full, empty, push, pop;
  logic [SW-1:0]   off_x;
  assign full        = cnt_q == CW'(RAS_DEPTH);
  assign empty       = cnt_q == '0;
  assign pc_plus1_o  = pc_q + 1'b1;
  assign off_x       = SW'($signed(branch_offset_i));
  assign br_tgt      = PC_W'(SW'(pc_plus1_o) + off_x);
  assign pc_o            = pc_q;
  assign ras_empty_o     = empty;
  assign ras_full_o      = full;
  assign ras_overflow_o  = ovf_q;
  assign ras_underflow_o = unf_q;
  // Priority select: ret > call > jump > branch > sequential; stall freezes everything
  always_comb begin
    push  = ~stall_i & ~ret_i & call_i;
    pop   = ~stall_i & ret_i & ~empty;
    unf_d = ~stall_i & ret_i & empty;
    ovf_d = push & full;
    pc_d  = stall_i ? pc_q :
            ret_i ? (empty ? pc_plus1_o : ras_q[top_q]) :
            (call_i | jump_i) ? jump_target_i :
            branch_taken_i ? br_tgt : pc_plus1_o;
    top_d = push ? top_q + 1'b1 : pop ? top_q - 1'b1 : top_q;
    cnt_d = (push & ~full) ? cnt_q + 1'b1 : pop ? cnt_q - 1'b1 : cnt_q;
  end
  // State registers; on overflow the oldest slot is simply overwritten by the wrapped pointer
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      pc_q  <= '0;
      top_q <= '0;
      cnt_q <= '0;
      ovf_q <= 1'b0;
      unf_q <= 1'b0;
      for (int i = 0; i < RAS_DEPTH; i++) ras_q[i] <= '0;
    end else begin
      pc_q  <= pc_d;
      top_q <= top_d;
      cnt_q <= cnt_d;
      ovf_q <= ovf_d;
      unf_q <= unf_d;
      if (push) ras_q[top_q + 1'b1] <= pc_plus1_o;
    end
  end
endmodule

// File: tb/tb_pc_sequencer.sv
// tb_pc_sequencer: directed self-checking bench for pc_sequencer
module tb_pc_sequencer;
  logic        clk = 1'b0, rst_n = 1'b0;
  logic        stall, br, jmp, call, ret;
  logic [16:0] off;
  logic [11:0] tgt, pc, pcp1;
  logic        empty, full, ovf, unf;
  int checks = 0, failures = 0;

  pc_sequencer dut (
    .clk_i(clk), .rst_ni(rst_n), .stall_i(stall), .branch_taken_i(br),
    .branch_offset_i(off), .jump_i(jmp), .call_i(call), .ret_i(ret),
    .jump_target_i(tgt), .pc_o(pc), .pc_plus1_o(pcp1), .ras_empty_o(empty),
    .ras_full_o(full), .ras_overflow_o(ovf), .ras_underflow_o(unf)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic idle();
    stall = 0; br = 0; jmp = 0; call = 0; ret = 0; off = '0; tgt = '0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_jump(input logic [11:0] t);
    idle(); jmp = 1; tgt = t; step(); idle();
  endtask

  task automatic do_call(input logic [11:0] t);
    idle(); call = 1; tgt = t; step(); idle();
  endtask

  task automatic do_ret();
    idle(); ret = 1; step(); idle();
  endtask

  initial begin
    idle();
    #2;
    chk("rst_pc", pc, 12'h000);
    chk("rst_empty", empty, 1'b1);
    chk("rst_full", full, 1'b0);
    chk("rst_ovf", ovf, 1'b0);
    chk("rst_unf", unf, 1'b0);
    #1 rst_n = 1;
    // 1: free-running sequential fetch
    for (int i = 1; i <= 5; i++) begin
      step();
      chk("seq_pc", pc, 32'(i));
      chk("seq_empty", empty, 1'b1);
    end
    // 2: wrap at top of address space
    do_jump(12'hFFE);
    chk("jmp_pc", pc, 12'hFFE);
    step();
    chk("wrap_fff", pc, 12'hFFF);
    chk("wrap_plus1", pcp1, 12'h000);
    step();
    chk("wrap_000", pc, 12'h000);
    // 3: relative branches
    do_jump(12'h010);
    br = 1; off = 17'h1FFFD; step(); idle();
    chk("br_neg", pc, 12'h00E);
    br = 1; off = 17'h00100; step(); idle();
    chk("br_pos", pc, 12'h10F);
    // 4: nested call/return
    do_jump(12'h020);
    do_call(12'h100);
    chk("call1_pc", pc, 12'h100);
    chk("call1_empty", empty, 1'b0);
    step();
    chk("call1_seq", pc, 12'h101);
    do_call(12'h200);
    chk("call2_pc", pc, 12'h200);
    do_ret();
    chk("ret1_pc", pc, 12'h102);
    do_ret();
    chk("ret2_pc", pc, 12'h021);
    chk("ret2_empty", empty, 1'b1);
    // 5: overflow then drain then underflow
    do_jump(12'h300);
    for (int i = 1; i <= 4; i++) begin
      do_call(12'(32'h300 + 32'h100 * i));
      chk("fill_full", full, i == 4);
      chk("fill_ovf", ovf, 1'b0);
    end
    do_call(12'h800);
    chk("ovf_pc", pc, 12'h800);
    chk("ovf_pulse", ovf, 1'b1);
    chk("ovf_full", full, 1'b1);
    do_ret();
    chk("drain1_pc", pc, 12'h701);
    chk("drain1_ovf", ovf, 1'b0);
    chk("drain1_full", full, 1'b0);
    do_ret();
    chk("drain2_pc", pc, 12'h601);
    do_ret();
    chk("drain3_pc", pc, 12'h501);
    do_ret();
    chk("drain4_pc", pc, 12'h401);
    chk("drain4_empty", empty, 1'b1);
    do_ret();
    chk("unf_pc", pc, 12'h402);
    chk("unf_pulse", unf, 1'b1);
    do_ret();
    chk("unf2_pc", pc, 12'h403);
    chk("unf2_pulse", unf, 1'b1);
    step();
    chk("unf_clear_pc", pc, 12'h404);
    chk("unf_clear", unf, 1'b0);
    // 6: call+ret together pops only
    do_call(12'h100);
    chk("pre_cr_pc", pc, 12'h100);
    call = 1; ret = 1; tgt = 12'h900; step(); idle();
    chk("cr_pc", pc, 12'h405);
    chk("cr_empty", empty, 1'b1);
    chk("cr_unf", unf, 1'b0);
    do_ret();
    chk("cr_nopush_pc", pc, 12'h406);
    chk("cr_nopush_unf", unf, 1'b1);
    // stall overrides jump and clears pulses
    stall = 1; jmp = 1; tgt = 12'hABC; step();
    chk("stall_pc", pc, 12'h406);
    chk("stall_unf", unf, 1'b0);
    stall = 1; jmp = 0; call = 1; step(); idle();
    chk("stall_call_pc", pc, 12'h406);
    chk("stall_call_empty", empty, 1'b1);
    // asynchronous reset between edges discards the stack
    do_call(12'h123);
    chk("prer_pc", pc, 12'h123);
    chk("prer_empty", empty, 1'b0);
    #2 rst_n = 0;
    #1;
    chk("async_pc", pc, 12'h000);
    chk("async_empty", empty, 1'b1);
    #1 rst_n = 1;
    step();
    chk("post_rst_pc", pc, 12'h001);
    do_ret();
    chk("post_rst_ret_pc", pc, 12'h002);
    chk("post_rst_unf", unf, 1'b1);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
